// File: rtl/data_mem_if.sv
// Request/response bus between an initiator and the data memory responder.
// One request in flight; the response is held until the initiator takes it.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte enables and a fixed response latency.
// Handles one transaction at a time: IDLE accepts, WAIT counts, RESP holds the answer.
module data_mem_responder #(
    parameter int unsigned ENTRY_COUNT = 32,
    parameter int unsigned LATENCY     = 2
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);

    localparam int unsigned IdxW       = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam logic [29:0] EntryLimit = 30'(ENTRY_COUNT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_in_rst;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [ENTRY_COUNT];
    logic [31:0] r_rdata;
    logic        r_err;

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic [29:0]     w_idx;
    logic [IdxW-1:0] w_mem_idx;
    logic            w_err;
    logic [31:0]     w_merged;

    assign bus.req_ready  = (r_state == StIdle) && !r_in_rst;
    assign bus.resp_valid = (r_state == StResp);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    assign w_accept     = bus.req_valid && bus.req_ready;
    assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

    // With LATENCY = 1 the commit happens on the accept edge, before the latch is loaded.
    assign w_we    = (r_state == StIdle) ? bus.req_we    : r_we;
    assign w_addr  = (r_state == StIdle) ? bus.req_addr  : r_addr;
    assign w_wdata = (r_state == StIdle) ? bus.req_wdata : r_wdata;
    assign w_be    = (r_state == StIdle) ? bus.req_be    : r_be;

    assign w_idx     = w_addr[31:2];
    assign w_mem_idx = w_addr[IdxW+1:2];
    assign w_err     = (w_addr[1:0] != 2'b00) || (w_idx >= EntryLimit);

    always_comb begin
        w_merged = r_mem[w_mem_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (LATENCY > 1) ? StWait : StResp;
                end
            end
            StWait: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_in_rst <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_in_rst <= 1'b0;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : r_mem[w_mem_idx];
                if (!w_err && w_we) begin
                    r_mem[w_mem_idx] <= w_merged;
                end
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ENTRY_COUNT, default 32, number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_be  input  4  byte enables; bit i enables bits [8i+7:8i].
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts response.
REQ-014 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-015 resp_err  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; exactly one transaction in flight.
REQ-017 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready.
REQ-018 On accept, req_we, req_addr, req_wdata and req_be SHALL be latched; later input changes have no effect on the transaction.
REQ-019 IDLE -> WAIT on accept when LATENCY > 1; IDLE -> RESP on accept when LATENCY = 1.
REQ-020 In WAIT, a down-counter loaded with LATENCY-1 on accept decrements each cycle; WAIT -> RESP when the counter reaches 1.
REQ-021 resp_valid SHALL be 1 exactly while in RESP, first asserted LATENCY cycles after the accept edge.
REQ-022 RESP -> IDLE when resp_ready = 1. resp_valid, resp_rdata and resp_err hold stable while resp_ready = 0.
REQ-023 Word index = latched addr[31:2]. Error = (addr[1:0] != 0) or (index >= ENTRY_COUNT).
REQ-024 On the edge entering RESP, a valid write SHALL merge wdata into the addressed word under be. Bytes with be = 0 are unchanged. be = 4'b0000 is a legal no-op write.
REQ-025 On the edge entering RESP, a valid read SHALL register the addressed word into resp_rdata.
REQ-026 An errored request SHALL NOT modify storage; it returns resp_err = 1 and resp_rdata = 0.
REQ-027 Outputs are registered or decoded from state only; no combinational path from req_* or resp_ready to any output.
REQ-028 Minimum initiator-visible period is LATENCY+1 cycles per transaction when resp_ready is held at 1.
REQ-029 A read that immediately follows a write to the same word SHALL return the merged value.

Reset
REQ-030 While rst = 1 at an edge: state = IDLE, counter = 0, all storage words = 0, resp_rdata = 0, resp_err = 0.
REQ-031 During and after reset: resp_valid = 0; req_ready = 1 starting in the first cycle after rst deasserts.
REQ-032 Reset in WAIT or RESP SHALL drop the transaction. A write not yet committed SHALL NOT take effect. Reset clears storage in any case.
REQ-033 req_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-034 Reset, then write addr 0x8, wdata 0xDEADBEEF, be 4'hF, resp_ready = 1 -> resp_valid 2 cycles after accept with err = 0. Then read 0x8 -> rdata 0xDEADBEEF.
REQ-035 Word 0x8 = 0xDEADBEEF; write wdata 0x000000AA, be 4'b0001; read 0x8 -> rdata 0xDEADBEAA.
REQ-036 Read addr 0x6 (misaligned) and read addr 0x80 with ENTRY_COUNT = 32 (out of range) -> resp_err = 1, rdata = 0, storage unchanged.
REQ-037 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready = 0 throughout. A req_valid pulse during this time is not accepted.
REQ-038 Accept write 0x4 with 0x12345678, assert rst in the WAIT cycle, then read 0x4 -> rdata 0x00000000.
REQ-039 With LATENCY = 1, issue back-to-back reads of 0x0 and 0x4, resp_ready = 1 -> resp_valid one cycle after each accept. Accepts are 2 cycles apart.
